// File: rtl/test_csr_bank.sv
// Purpose : Avalon-MM CSR bank that launches a test, passes it parameters and collects its results.
// Latency : reads return exactly 2 cycles after read_i; writes take effect on the accepting edge.
// Backpr. : none -- a read or write is accepted every cycle and nothing is ever stalled.
module test_csr_bank #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int PARAM_CNT  = 8,
  parameter int RESULT_CNT = 4
) (
  input  logic                         clk_sys_i,
  input  logic                         rst_n_i,
  input  logic                         read_i,
  input  logic                         write_i,
  input  logic [ADDR_W-1:0]            address_i,
  input  logic [DATA_W-1:0]            writedata_i,
  input  logic [DATA_W/8-1:0]          byteenable_i,
  output logic                         readdatavalid_o,
  output logic [DATA_W-1:0]            readdata_o,
  output logic                         resp_err_o,
  input  logic                         test_finished_i,
  input  logic [RESULT_CNT*DATA_W-1:0] test_result_i,
  output logic                         test_start_o,
  output logic                         test_abort_o,
  output logic [PARAM_CNT*DATA_W-1:0]  test_param_o,
  output logic                         irq_o
);

  localparam int BE_W       = DATA_W / 8;
  localparam int PARAM_BASE = 2;
  localparam int RES_BASE   = PARAM_BASE + PARAM_CNT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The register map must fit inside the address space and lanes must be whole bytes.
  if ((RES_BASE + RESULT_CNT > (1 << ADDR_W)) || (DATA_W % 8 != 0)) begin : g_bad_params
    $error("test_csr_bank: register map does not fit ADDR_W or DATA_W is not a byte multiple");
  end

  logic [1:0]        state_q, state_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              irq_en_q, irq_en_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              irq_q;
  logic              fin_q;
  logic [DATA_W-1:0] param_q  [PARAM_CNT];
  logic [DATA_W-1:0] param_d  [PARAM_CNT];
  logic [DATA_W-1:0] result_q [RESULT_CNT];
  logic [DATA_W-1:0] result_d [RESULT_CNT];

  // Read pipeline: stage 1 holds the sampled value, stage 2 drives the bus.
  logic              rd_vld1_q, rd_err1_q;
  logic [DATA_W-1:0] rd_dat1_q;
  logic              rd_vld2_q, rd_err2_q;
  logic [DATA_W-1:0] rd_dat2_q;

  logic              busy;
  logic              fin_rise;
  logic              wr_ctrl;
  logic              start_req;
  logic              abort_req;
  logic              rd_status;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_err;

  assign busy      = (state_q == ST_RUN);
  assign fin_rise  = test_finished_i & ~fin_q;
  assign wr_ctrl   = write_i && (address_i == ADDR_W'(0)) && byteenable_i[0];
  assign start_req = wr_ctrl & writedata_i[0];
  assign abort_req = wr_ctrl & writedata_i[1];
  assign rd_status = read_i && (address_i == ADDR_W'(1));

  // Read decode from current (pre-write, pre-clear) register values.
  always_comb begin
    rd_dat = '0;
    rd_err = 1'b1;
    if (address_i == ADDR_W'(0)) begin
      rd_dat[2] = irq_en_q;
      rd_err    = 1'b0;
    end
    if (address_i == ADDR_W'(1)) begin
      rd_dat[2:0] = {aborted_q, done_q, busy};
      rd_err      = 1'b0;
    end
    for (int i = 0; i < PARAM_CNT; i++) begin
      if (address_i == ADDR_W'(PARAM_BASE + i)) begin
        rd_dat = param_q[i];
        rd_err = 1'b0;
      end
    end
    for (int k = 0; k < RESULT_CNT; k++) begin
      if (address_i == ADDR_W'(RES_BASE + k)) begin
        rd_dat = result_q[k];
        rd_err = 1'b0;
      end
    end
  end

  // Next-state for the FSM, status flags, pulses, parameters and captured results.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    irq_en_d  = irq_en_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    param_d   = param_q;
    result_d  = result_q;

    // Read-to-clear; any set below in the same cycle overrides it.
    if (rd_status) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    if (wr_ctrl) begin
      irq_en_d = writedata_i[2];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_d   = ST_RUN;
          start_d   = 1'b1;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_RUN: begin
        // A finish edge beats a simultaneous abort so the results are never lost.
        if (fin_rise) begin
          for (int k = 0; k < RESULT_CNT; k++) begin
            result_d[k] = test_result_i[k*DATA_W +: DATA_W];
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (abort_req) begin
          abort_d   = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Parameters are frozen while a test is running.
    if (write_i && !busy) begin
      for (int i = 0; i < PARAM_CNT; i++) begin
        if (address_i == ADDR_W'(PARAM_BASE + i)) begin
          for (int b = 0; b < BE_W; b++) begin
            if (byteenable_i[b]) begin
              param_d[i][8*b +: 8] = writedata_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_en_q  <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      irq_q     <= 1'b0;
      fin_q     <= 1'b0;
      rd_vld1_q <= 1'b0;
      rd_err1_q <= 1'b0;
      rd_dat1_q <= '0;
      rd_vld2_q <= 1'b0;
      rd_err2_q <= 1'b0;
      rd_dat2_q <= '0;
      for (int i = 0; i < PARAM_CNT; i++) param_q[i] <= '0;
      for (int k = 0; k < RESULT_CNT; k++) result_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      irq_en_q  <= irq_en_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      irq_q     <= irq_en_q & (done_q | aborted_q);
      fin_q     <= test_finished_i;
      rd_vld1_q <= read_i;
      rd_err1_q <= read_i & rd_err;
      rd_dat1_q <= read_i ? rd_dat : '0;
      rd_vld2_q <= rd_vld1_q;
      rd_err2_q <= rd_err1_q;
      rd_dat2_q <= rd_dat1_q;
      param_q   <= param_d;
      result_q  <= result_d;
    end
  end

  // Flatten the parameter registers onto the test-facing bus.
  always_comb begin
    test_param_o = '0;
    for (int i = 0; i < PARAM_CNT; i++) begin
      test_param_o[i*DATA_W +: DATA_W] = param_q[i];
    end
  end

  assign readdatavalid_o = rd_vld2_q;
  assign readdata_o      = rd_dat2_q;
  assign resp_err_o      = rd_err2_q;
  assign test_start_o    = start_q;
  assign test_abort_o    = abort_q;
  assign irq_o           = irq_q;

endmodule

// File: doc/test_csr_bank.md
TEST_CSR_BANK -- requirements
Module: test_csr_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the CSR and bus data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 4, the word-address width.
REQ-003 SHALL have parameter PARAM_CNT, default 8, the number of RW test-parameter registers.
REQ-004 SHALL have parameter RESULT_CNT, default 4, the number of RO result registers; 2+PARAM_CNT+RESULT_CNT <= 2**ADDR_W, with elaboration failing otherwise.
REQ-005 SHALL have port clk_sys_i  in  1  the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n_i  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port read_i / write_i  in  1 each  Avalon-MM read/write strobes.
REQ-008 SHALL have port address_i  in  ADDR_W  word address.
REQ-009 SHALL have port writedata_i  in  DATA_W  write data.
REQ-010 SHALL have port byteenable_i  in  DATA_W/8  write byte lanes.
REQ-011 SHALL have port readdatavalid_o  out  1  read data valid.
REQ-012 SHALL have port readdata_o  out  DATA_W  read data.
REQ-013 SHALL have port resp_err_o  out  1  error flag, qualified by readdatavalid_o.
REQ-014 SHALL have port test_finished_i  in  1  level, finish indication from checker.
REQ-015 SHALL have port test_result_i  in  RESULT_CNT*DATA_W  result vector; word k maps to result register k.
REQ-016 SHALL have ports test_start_o and test_abort_o  out  1 each  single-cycle pulses.
REQ-017 SHALL have port test_param_o  out  PARAM_CNT*DATA_W  current parameter registers.
REQ-018 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-019 SHALL implement the map: 0 CONTROL (bit0 START W1, bit1 ABORT W1, bit2 IRQ_EN RW; other bits read 0); 1 STATUS RO (bit0 BUSY, bit1 DONE, bit2 ABORTED); 2..2+PARAM_CNT-1 PARAM; then RESULT_CNT RESULT words; higher addresses unmapped.
REQ-020 SHALL honour byteenable_i on PARAM and CONTROL writes; START/ABORT/IRQ_EN act only when byte lane 0 is enabled.
REQ-021 SHALL run FSM IDLE/RUN/DONE: IDLE or DONE + START write -> RUN with test_start_o high the next cycle for exactly 1 cycle, clearing DONE and ABORTED.
REQ-022 SHALL, in RUN, on a rising edge of test_finished_i (1-cycle edge detect) capture all test_result_i words into RESULT, set DONE, go to DONE.
REQ-023 SHALL, in RUN, on an ABORT write, pulse test_abort_o for 1 cycle, set ABORTED, go to IDLE; results are unchanged.
REQ-024 SHALL ignore START in RUN, ABORT outside RUN, and PARAM writes while BUSY (BUSY = state RUN).
REQ-025 SHALL give finish priority over ABORT in the same cycle: capture occurs, DONE is set, and no abort pulse is generated.
REQ-026 SHALL clear DONE and ABORTED on a read of STATUS; a same-cycle set wins and the read returns the pre-set value.
REQ-027 SHALL drive irq_o = IRQ_EN & (DONE | ABORTED), registered, updating 1 cycle after the underlying bits change.
REQ-028 SHALL return read data with fixed latency 2: read_i at cycle N -> readdatavalid_o high at N+2 for 1 cycle; back-to-back reads are accepted every cycle.
REQ-029 SHALL, on an unmapped read, return readdata_o = 0 with resp_err_o = 1; unmapped writes and writes to STATUS/RESULT are silently dropped.
REQ-030 SHALL treat read_i and write_i asserted together as a write followed by a read of the pre-write value.

Reset
REQ-031 SHALL, while rst_n_i is low at a clock edge, set the state to IDLE; clear all CSRs to 0; and drive readdatavalid_o, readdata_o, resp_err_o, test_start_o, test_abort_o and irq_o to 0.
REQ-032 SHALL discard reads in flight when reset is asserted mid-read, with no readdatavalid_o after release.
REQ-033 SHALL, on reset during RUN, return to IDLE with no abort pulse.

Verification
REQ-034 SHALL cover: write PARAM[0]=0xDEADBEEF with byteenable 0x3, then read -> 0x0000BEEF at latency 2.
REQ-035 SHALL cover: write CONTROL=0x5, then pulse test_finished_i with results 0x11,0x22,0x33,0x44 -> 1 test_start_o pulse; STATUS reads 0x2; irq_o=1; RESULT words are 0x11..0x44; the next STATUS read returns 0x0 and irq_o drops.
REQ-036 SHALL cover: in RUN, write PARAM[1]=0x5 and CONTROL=0x2 -> PARAM[1] is unchanged, 1 test_abort_o pulse, STATUS=0x4.
REQ-037 SHALL cover: ABORT write in the same cycle as the finish edge -> no abort pulse and STATUS=0x2.
REQ-038 SHALL cover: read of address 15 at defaults -> readdata_o 0, resp_err_o 1.
REQ-039 SHALL cover: assert rst_n_i low during RUN with a read in flight -> all outputs 0, state IDLE, no stray readdatavalid_o.
